alu_pipe: RTL and testbench

Parametrised, pipelined ALU that replaces the single-cycle combinational ALU in the datapath. It accepts operand/opcode triples through a valid/ready handshake, computes the result in a two-stage pipeline with full backpressure, and returns the result with status flags and an invalid-opcode indication. The opcode set and the invalid-opcode result (all ones) match the existing ALU, so existing directed checks port over unchanged.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_pipe.sv | 84 ++++++++
 tb/tb_alu_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and invalid-result rule for the pipelined ALU.
// Define ALU_FLAGS_EN at build time to enable the N/Z/C/V flag logic.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Unrecognised opcodes produce an all-ones result of whatever width is in use.
  localparam bit INVALID_FILL = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, {N,Z,C,V} flags and invalid-opcode indication.
// Flags are only built when ALU_FLAGS_EN is defined; otherwise they are tied to zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
) (
  input  logic [NBITS-1:0]  a,
  input  logic [NBITS-1:0]  b,
  input  logic [COD_OP-1:0] op,
  output logic [NBITS-1:0]  result,
  output logic [3:0]        flags,
  output logic              invalid
);

  // Opcodes are compared zero-extended, so any set bit above bit 5 falls to default.
  always_comb begin
    result  = '0;
    invalid = 1'b0;
    case (op)
      COD_OP'(OP_ADD): result = a + b;
      COD_OP'(OP_SUB): result = a - b;
      COD_OP'(OP_AND): result = a & b;
      COD_OP'(OP_OR):  result = a | b;
      COD_OP'(OP_XOR): result = a ^ b;
      COD_OP'(OP_NOR): result = ~(a | b);
      COD_OP'(OP_SRL): result = a >> b;
      COD_OP'(OP_SRA): result = $signed(a) >>> b;
      default: begin
        result  = {NBITS{INVALID_FILL}};
        invalid = 1'b1;
      end
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [NBITS:0] add_w;
  logic [NBITS:0] sub_w;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    flags = '0;
    if (!invalid) begin
      flags[FLAG_N] = result[NBITS-1];
      flags[FLAG_Z] = (result == '0);
      if (op == COD_OP'(OP_ADD)) begin
        flags[FLAG_C] = add_w[NBITS];
        flags[FLAG_V] = (a[NBITS-1] == b[NBITS-1]) && (add_w[NBITS-1] != a[NBITS-1]);
      end else if (op == COD_OP'(OP_SUB)) begin
        // The extra MSB of the widened difference is the borrow (A < B unsigned).
        flags[FLAG_C] = sub_w[NBITS];
        flags[FLAG_V] = (a[NBITS-1] != b[NBITS-1]) && (sub_w[NBITS-1] != a[NBITS-1]);
      end
    end
  end
`else
  assign flags = '0;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline around alu_core; fixed latency, 1 op/cycle, full backpressure.
// Flag generation is controlled by the ALU_FLAGS_EN macro (disabled by default).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBITS-1:0]  operando_A,
  input  logic [NBITS-1:0]  operando_B,
  input  logic [COD_OP-1:0] cod_operacion,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NBITS-1:0]  ALU_Result,
  output logic [3:0]        flags,
  output logic              op_invalid,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              s1_valid;
  logic [NBITS-1:0]  s1_a;
  logic [NBITS-1:0]  s1_b;
  logic [COD_OP-1:0] s1_op;

  logic [NBITS-1:0]  core_result;
  logic [3:0]        core_flags;
  logic              core_invalid;

  logic              s2_adv;
  logic              s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  alu_core #(
    .NBITS  (NBITS),
    .COD_OP (COD_OP)
  ) u_core (
    .a       (s1_a),
    .b       (s1_b),
    .op      (s1_op),
    .result  (core_result),
    .flags   (core_flags),
    .invalid (core_invalid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= operando_A;
        s1_b  <= operando_B;
        s1_op <= cod_operacion;
      end
    end
  end

  // Output registers only reload with a live op, so a drained pipe keeps its last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      ALU_Result <= '0;
      flags      <= '0;
      op_invalid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ALU_Result <= core_result;
        flags      <= core_flags;
        op_invalid <= core_invalid;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (NBITS=8); expected flags follow the ALU_FLAGS_EN build setting.
module tb_alu_pipe;

  localparam int NBITS  = 8;
  localparam int COD_OP = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NBITS-1:0]  operando_A;
  logic [NBITS-1:0]  operando_B;
  logic [COD_OP-1:0] cod_operacion;
  logic              in_valid;
  logic              in_ready;
  logic [NBITS-1:0]  ALU_Result;
  logic [3:0]        flags;
  logic              op_invalid;
  logic              out_valid;
  logic              out_ready;

  alu_pipe #(.NBITS(NBITS), .COD_OP(COD_OP)) dut (
    .clk           (clk),
    .reset         (reset),
    .operando_A    (operando_A),
    .operando_B    (operando_B),
    .cod_operacion (cod_operacion),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ALU_Result    (ALU_Result),
    .flags         (flags),
    .op_invalid    (op_invalid),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       inv;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    exp_t e;
    int   s, sa, sbv;
    logic c, v;
    e.res = 8'h00; e.inv = 1'b0; e.acc = 0; e.lat = 1'b0;
    c = 1'b0; v = 1'b0;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (op)
      6'b100000: begin s = int'(a) + int'(b); e.res = s[7:0]; c = (s > 255);
                       v = (sa + sbv > 127) || (sa + sbv < -128); end
      6'b100010: begin s = int'(a) - int'(b); e.res = s[7:0]; c = (a < b);
                       v = (sa - sbv > 127) || (sa - sbv < -128); end
      6'b100100: e.res = a & b;
      6'b100101: e.res = a | b;
      6'b100110: e.res = a ^ b;
      6'b100111: e.res = ~(a | b);
      6'b000011: begin
        if (b >= 8) e.res = a[7] ? 8'hFF : 8'h00;
        else        e.res = 8'(sa >>> b);
      end
      6'b000010: e.res = (b >= 8) ? 8'h00 : (a >> b);
      default: begin e.res = 8'hFF; e.inv = 1'b1; end
    endcase
    e.flg = e.inv ? 4'b0000 : {e.res[7], (e.res == 8'h00), c, v};
`ifndef ALU_FLAGS_EN
    e.flg = 4'b0000;
`endif
    return e;
  endfunction

  // Output monitor: pops the scoreboard on each output handshake, checks hold while stalled.
  exp_t       mon_e;
  bit         stalled = 1'b0;
  logic [7:0] hold_res;
  logic [3:0] hold_flg;
  logic       hold_inv;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        check_val("hold_result", ALU_Result, hold_res);
        check_val("hold_flags", flags, hold_flg);
        check_val("hold_invalid", op_invalid, hold_inv);
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("spurious_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("result", ALU_Result, mon_e.res);
          check_val("flags", flags, mon_e.flg);
          check_val("op_invalid", op_invalid, mon_e.inv);
          if (mon_e.lat) check_val("latency_edges", cyc - mon_e.acc + 1, 2);
        end
      end else if (out_valid) begin
        stalled  = 1'b1;
        hold_res = ALU_Result;
        hold_flg = flags;
        hold_inv = op_invalid;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    exp_t e;
    bit   ok;
    int   n;
    n = 0;
    operando_A = a; operando_B = b; cod_operacion = op; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      check_val("accept_timeout", 0, 1);
    end else begin
      e = model(a, b, op);
      e.acc = cyc;
      e.lat = lat_mode;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b000011, 6'b000010, 6'b100111};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    operando_A = '0; operando_B = '0; cod_operacion = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", ALU_Result, 0);
    check_val("rst_flags", flags, 0);
    check_val("rst_op_invalid", op_invalid, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, streamed back to back with out_ready high.
    lat_mode = 1'b1;
    send(8'hFF, 8'h01, 6'b100000);
    send(8'h80, 8'h01, 6'b100010);
    send(8'h01, 8'h02, 6'b100010);
    send(8'h90, 8'h02, 6'b000011);
    send(8'h90, 8'h09, 6'b000011);
    send(8'h90, 8'h09, 6'b000010);
    send(8'h90, 8'h03, 6'b000010);
    send(8'h12, 8'h34, 6'b000000);
    send(8'h7F, 8'h01, 6'b100000);
    send(8'hF0, 8'h3C, 6'b100100);
    send(8'hF0, 8'h3C, 6'b100101);
    send(8'hF0, 8'h3C, 6'b100110);
    send(8'hF0, 8'h0C, 6'b100111);
    send(8'h55, 8'h55, 6'b100010);
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 4 edges while 5 ADDs are offered.
    lat_mode = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(8'(i), 8'(i), 6'b100000);
        in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        check_val("in_ready_one_held", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check_val("in_ready_full", in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random opcodes and operands under random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 5) == 0)
            send(8'($urandom), 8'($urandom_range(0, 12)), 6'($urandom));
          else
            send(8'($urandom), 8'($urandom_range(0, 12)), ops[$urandom_range(0, 7)]);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(8'h03, 8'h04, 6'b100000);
    send(8'h0F, 8'hF0, 6'b100110);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_result", ALU_Result, 0);
    check_val("midrst_flags", flags, 0);
    check_val("midrst_op_invalid", op_invalid, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_mode = 1'b1;
    send(8'h10, 8'h20, 6'b100000);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
